stream_downsize: RTL and testbench

- Width-down converter for the team's stream protocol; the transmit-side counterpart of the upsizer.
- Accepts one wide beat: T_DATA_RATIO lanes of T_DATA_WIDTH bits, plus a per-lane keep mask and last.
- Emits only the kept lanes as narrow beats, lowest lane first.
- Sits between a wide datapath and a narrow sink (e.g. serializer, narrow FIFO).

---
 rtl/stream_pkg.sv | 25 ++
 rtl/stream_lane_pick.sv | 19 +
 rtl/stream_downsize.sv | 104 ++++++++++
 tb/tb_stream_downsize.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream width converters.
package stream_pkg;

  localparam int MAX_LANES = 64;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  function automatic int idx_width(input int ratio);
    return (ratio > 2) ? $clog2(ratio) : 1;
  endfunction

  // Returns 0 for an empty mask; callers qualify with their own valid state.
  function automatic int lowest_set_idx(input logic [MAX_LANES-1:0] mask);
    int idx;
    idx = 0;
    for (int i = MAX_LANES - 1; i >= 0; i--) begin
      if (mask[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/stream_lane_pick.sv
// Priority encoder over a lane mask: lowest set lane, the mask without it,
// and whether that lane is the last one left.
module stream_lane_pick
  import stream_pkg::*;
#(
  parameter  int RATIO = 2,
  localparam int IDX_W = idx_width(RATIO)
) (
  input  logic [RATIO-1:0] mask_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [RATIO-1:0] rest_o,
  output logic             final_o
);

  assign idx_o   = IDX_W'(lowest_set_idx(MAX_LANES'(mask_i)));
  assign rest_o  = mask_i & (mask_i - RATIO'(1));
  assign final_o = (rest_o == '0);

endmodule

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: emits the kept lanes of each wide beat,
// lowest lane first, one narrow beat per cycle.
//
// state | meaning
// IDLE  | no lanes pending; ready for a wide beat
// SEND  | presenting lane data_q[idx]; rem_q holds lanes still to send
module stream_downsize
  import stream_pkg::*;
#(
  parameter int T_DATA_WIDTH = 1,
  parameter int T_DATA_RATIO = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO],
  input  logic [T_DATA_RATIO-1:0] s_keep_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);

  localparam int IDX_W = idx_width(T_DATA_RATIO);

  state_e                  state_q, state_d;
  logic [T_DATA_WIDTH-1:0] data_q [T_DATA_RATIO];
  logic [T_DATA_RATIO-1:0] rem_q;
  logic                    last_q;

  logic [IDX_W-1:0]        idx;
  logic [T_DATA_RATIO-1:0] rem_rest;
  logic                    is_final;
  logic                    load;
  logic                    m_hs;

  stream_lane_pick #(
    .RATIO (T_DATA_RATIO)
  ) u_lane_pick (
    .mask_i  (rem_q),
    .idx_o   (idx),
    .rest_o  (rem_rest),
    .final_o (is_final)
  );

  assign m_hs = (state_q == SEND) && m_ready_i;

  // s_ready_o follows m_ready_i combinationally so the final lane and the
  // next wide beat can hand over in the same cycle.
  always_comb begin
    state_d   = state_q;
    s_ready_o = 1'b0;
    m_valid_o = 1'b0;
    m_data_o  = '0;
    m_last_o  = 1'b0;
    load      = 1'b0;
    unique case (state_q)
      IDLE: begin
        s_ready_o = 1'b1;
        if (s_valid_i && (s_keep_i != '0)) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        m_valid_o = 1'b1;
        m_data_o  = data_q[idx];
        m_last_o  = last_q && is_final;
        if (m_hs && is_final) begin
          s_ready_o = 1'b1;
          if (s_valid_i && (s_keep_i != '0)) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      last_q  <= 1'b0;
      for (int i = 0; i < T_DATA_RATIO; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (load) begin
        data_q <= s_data_i;
        rem_q  <= s_keep_i;
        last_q <= s_last_i;
      end else if (m_hs) begin
        rem_q <= rem_rest;
      end
    end
  end

endmodule

// File: tb/tb_stream_downsize.sv
// Self-checking bench for stream_downsize (8-bit lanes, 4 lanes per beat).
module tb_stream_downsize;

  localparam int W = 8;
  localparam int R = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] s_data [R];
  logic [R-1:0] s_keep;
  logic         s_last;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] m_data;
  logic         m_last;
  logic         m_valid;
  logic         m_ready;

  stream_downsize #(
    .T_DATA_WIDTH (W),
    .T_DATA_RATIO (R)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data_i  (s_data),
    .s_keep_i  (s_keep),
    .s_last_i  (s_last),
    .s_valid_i (s_valid),
    .s_ready_o (s_ready),
    .m_data_o  (m_data),
    .m_last_o  (m_last),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of narrow beats owed by the DUT.
  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } nb_t;

  nb_t          exp_q[$];
  logic         stall_q = 1'b0;
  logic [W-1:0] hold_d;
  logic         hold_l;

  always @(negedge clk) begin
    if (rst_n) begin
      exp_q.delete();
      stall_q = 1'b0;
    end else begin
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("mon_unexpected_beat", 32'(m_valid), 32'd0);
        end else begin
          nb_t e;
          e = exp_q.pop_front();
          chk("mon_data", 32'(m_data), 32'(e.d));
          chk("mon_last", 32'(m_last), 32'(e.l));
        end
      end
      if (stall_q) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(hold_d));
        chk("hold_last", 32'(m_last), 32'(hold_l));
      end
      stall_q = m_valid && !m_ready;
      hold_d  = m_data;
      hold_l  = m_last;
      if (s_valid && s_ready) begin
        int hi;
        hi = -1;
        for (int i = 0; i < R; i++) if (s_keep[i]) hi = i;
        for (int i = 0; i < R; i++) begin
          if (s_keep[i]) exp_q.push_back({s_data[i], s_last && (i == hi)});
        end
      end
    end
  end

  typedef struct packed {
    logic [R-1:0][W-1:0] data;
    logic [R-1:0]        keep;
    logic                last;
    logic [2:0]          exp_n;
    logic [R-1:0][W-1:0] exp_data;
    logic                exp_last;
  } vec_t;

  vec_t vecs [7];

  task automatic drive_beat(input logic [R-1:0][W-1:0] d, input logic [R-1:0] k, input logic l);
    for (int i = 0; i < R; i++) s_data[i] = d[i];
    s_keep  = k;
    s_last  = l;
    s_valid = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] bp_pat;
  int         sent;
  logic       was_acc;

  initial begin
    vecs[0] = '{data: {8'h13, 8'h12, 8'h11, 8'h10}, keep: 4'b1111, last: 1'b1,
                exp_n: 3'd4, exp_data: {8'h13, 8'h12, 8'h11, 8'h10}, exp_last: 1'b1};
    vecs[1] = '{data: {8'hA3, 8'hA2, 8'hA1, 8'hA0}, keep: 4'b1010, last: 1'b1,
                exp_n: 3'd2, exp_data: {8'h00, 8'h00, 8'hA3, 8'hA1}, exp_last: 1'b1};
    vecs[2] = '{data: {8'hE3, 8'hE2, 8'hE1, 8'hE0}, keep: 4'b0000, last: 1'b1,
                exp_n: 3'd0, exp_data: '0, exp_last: 1'b0};
    vecs[3] = '{data: {8'h53, 8'h52, 8'h51, 8'h50}, keep: 4'b0001, last: 1'b0,
                exp_n: 3'd1, exp_data: {8'h00, 8'h00, 8'h00, 8'h50}, exp_last: 1'b0};
    vecs[4] = '{data: {8'h63, 8'h62, 8'h61, 8'h60}, keep: 4'b0001, last: 1'b1,
                exp_n: 3'd1, exp_data: {8'h00, 8'h00, 8'h00, 8'h60}, exp_last: 1'b1};
    vecs[5] = '{data: {8'hC3, 8'hC2, 8'hC1, 8'hC0}, keep: 4'b1000, last: 1'b1,
                exp_n: 3'd1, exp_data: {8'h00, 8'h00, 8'h00, 8'hC3}, exp_last: 1'b1};
    vecs[6] = '{data: {8'hD3, 8'hD2, 8'hD1, 8'hD0}, keep: 4'b0110, last: 1'b0,
                exp_n: 3'd2, exp_data: {8'h00, 8'h00, 8'hD2, 8'hD1}, exp_last: 1'b0};

    rst_n   = 1'b1;
    s_valid = 1'b0;
    s_keep  = '0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < R; i++) s_data[i] = '0;
    step();
    step();
    rst_n = 1'b0;

    @(negedge clk);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    step();

    // Single-beat vectors, sink always ready.
    for (int v = 0; v < 7; v++) begin
      drive_beat(vecs[v].data, vecs[v].keep, vecs[v].last);
      @(negedge clk);
      chk("vec_s_ready", 32'(s_ready), 32'd1);
      step();
      s_valid = 1'b0;
      for (int k = 0; k < int'(vecs[v].exp_n); k++) begin
        @(negedge clk);
        chk("vec_m_valid", 32'(m_valid), 32'd1);
        chk("vec_m_data", 32'(m_data), 32'(vecs[v].exp_data[k]));
        chk("vec_m_last", 32'(m_last), 32'(vecs[v].exp_last && (k == int'(vecs[v].exp_n) - 1)));
        step();
      end
      @(negedge clk);
      chk("vec_idle_valid", 32'(m_valid), 32'd0);
      chk("vec_idle_ready", 32'(s_ready), 32'd1);
      step();
    end

    // Back-to-back full beats with no bubble.
    drive_beat({8'h13, 8'h12, 8'h11, 8'h10}, 4'b1111, 1'b0);
    @(negedge clk);
    chk("b2b_first_ready", 32'(s_ready), 32'd1);
    step();
    drive_beat({8'h23, 8'h22, 8'h21, 8'h20}, 4'b1111, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("b2b_m_valid", 32'(m_valid), 32'd1);
      chk("b2b_m_data", 32'(m_data), (i < 4) ? 32'(8'h10 + i) : 32'(8'h20 + i - 4));
      chk("b2b_m_last", 32'(m_last), 32'(i == 7));
      chk("b2b_s_ready", 32'(s_ready), 32'((i == 3) || (i == 7)));
      step();
      if (i == 3) s_valid = 1'b0;
    end
    @(negedge clk);
    chk("b2b_end_valid", 32'(m_valid), 32'd0);
    step();

    // Backpressure pattern 0,0,1,0,1,1,0,1.
    bp_pat = 8'b1011_0100;
    drive_beat({8'h33, 8'h32, 8'h31, 8'h30}, 4'b1111, 1'b1);
    @(negedge clk);
    step();
    s_valid = 1'b0;
    sent = 0;
    for (int c = 0; c < 8; c++) begin
      m_ready = bp_pat[c];
      @(negedge clk);
      chk("bp_m_valid", 32'(m_valid), 32'd1);
      chk("bp_m_data", 32'(m_data), 32'(8'h30 + sent));
      chk("bp_m_last", 32'(m_last), 32'(sent == 3));
      if (bp_pat[c]) sent++;
      step();
    end
    m_ready = 1'b1;
    @(negedge clk);
    chk("bp_end_valid", 32'(m_valid), 32'd0);
    step();

    // Reset after two of four lanes.
    drive_beat({8'h43, 8'h42, 8'h41, 8'h40}, 4'b1111, 1'b1);
    @(negedge clk);
    step();
    s_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rmid_m_data", 32'(m_data), 32'(8'h40 + k));
      step();
    end
    rst_n   = 1'b1;
    m_ready = 1'b0;
    step();
    rst_n   = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rmid_m_valid", 32'(m_valid), 32'd0);
      chk("rmid_s_ready", 32'(s_ready), 32'd1);
      step();
    end

    // Randomized traffic against the monitor's reference queue.
    was_acc = 1'b1;
    s_valid = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!s_valid || was_acc) begin
        logic [R-1:0][W-1:0] rd;
        for (int i = 0; i < R; i++) rd[i] = W'($urandom);
        drive_beat(rd, R'($urandom_range(0, 15)), 1'($urandom));
        s_valid = ($urandom_range(0, 3) != 0);
      end
      m_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      was_acc = s_valid && s_ready;
      step();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 8; c++) step();
    @(negedge clk);
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    chk("rand_idle_valid", 32'(m_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
